reg_piso_unload: RTL

//  Parallel-in/serial-out unload register for the assembly-line datapath.
//  A WIDTH-bit word is captured in parallel, then shifted out one bit per accepted beat.

---
 rtl/reg_piso_unload.sv | 49 ++++
 1 files changed

// File: rtl/reg_piso_unload.sv
// reg_piso_unload: parallel-in/serial-out unload register with valid/ready bit stream
module reg_piso_unload #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    output logic             ready,
    output logic             rez,
    output logic             rez_valid,
    input  logic             rez_ready,
    output logic             last,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0] count;
    logic beat, take;
    assign rez_valid = state == SHIFT;
    assign rez = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign last = rez_valid && count == CW'(WIDTH - 1);
    assign beat = rez_valid & rez_ready;
    // ready looks through rez_ready so a new word can follow the final beat with no bubble
    assign ready = state == IDLE || (last && rez_ready);
    assign take = load & ready;
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            sr    <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= beat & last;
            if (take) begin
                sr    <= a;
                count <= '0;
                state <= SHIFT;
            end else if (beat) begin
                sr    <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
                count <= last ? '0 : count + 1'b1;
                state <= last ? IDLE : SHIFT;
            end
        end
    end
endmodule
